mouse_transmitter: RTL and testbench

PS/2 host-to-device transmitter that sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse. It is the transmit counterpart of the mouse receive path. Both sit under the mouse master FSM and share the open-collector CLK/DATA lines. It performs bus inhibit and request-to-send, shifts out the data, parity and stop bits on device-generated clock edges, checks the device ACK, and reports completion or error.

---
 rtl/mouse_pkg.sv | 28 ++
 rtl/mouse_transmitter_if.sv | 27 ++
 rtl/ps2_edge_detect.sv | 23 ++
 rtl/mouse_transmitter.sv | 140 ++++++++++++++
 tb/tb_mouse_transmitter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared PS/2 mouse types, timing constants and command codes
package mouse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND_DATA,
        S_STOP,
        S_ACK,
        S_RELEASE
    } tx_state_e;

    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_NO_ACK  = 1;

    // 50 MHz system clock: 120 us inhibit, 2 ms per-edge timeout
    localparam int CLK_HOLD_CYCLES_50M = 6000;
    localparam int TIMEOUT_CYCLES_50M  = 100000;

    localparam logic [7:0] CMD_ENABLE_REPORTING = 8'hF4;
    localparam logic [7:0] CMD_RESET            = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/mouse_transmitter_if.sv
// rtl/mouse_transmitter_if.sv - PS/2 line and command handshake bundle for the transmitter
// slave  : transmitter side (samples lines and SEND_BYTE, drives enables/status)
// master : controller/pad side (drives lines and SEND_BYTE, observes status)
interface mouse_transmitter_if;
    logic       CLK_MOUSE_IN;
    logic       DATA_MOUSE_IN;
    logic       CLK_MOUSE_OUT_EN;
    logic       DATA_MOUSE_OUT;
    logic       DATA_MOUSE_OUT_EN;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       TX_BUSY;
    logic       BYTE_SENT;
    logic [1:0] BYTE_ERROR_CODE;

    modport slave (
        input  CLK_MOUSE_IN, DATA_MOUSE_IN, SEND_BYTE, BYTE_TO_SEND,
        output CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN,
               TX_BUSY, BYTE_SENT, BYTE_ERROR_CODE
    );

    modport master (
        output CLK_MOUSE_IN, DATA_MOUSE_IN, SEND_BYTE, BYTE_TO_SEND,
        input  CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN,
               TX_BUSY, BYTE_SENT, BYTE_ERROR_CODE
    );
endinterface

// File: rtl/ps2_edge_detect.sv
// rtl/ps2_edge_detect.sv - falling-edge detector for a sampled PS/2 line
// clk_i, rst_ni : system clock, async active-low reset
// line_i        : sampled PS/2 line
// fe_o          : high for the cycle in which the line is seen going 1 -> 0
module ps2_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic fe_o
);
    logic line_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= 1'b0;
        end else begin
            line_q <= line_i;
        end
    end

    assign fe_o = line_q & ~line_i;

endmodule

// File: rtl/mouse_transmitter.sv
// rtl/mouse_transmitter.sv - PS/2 host-to-device command byte transmitter
// CLK, RESET : system clock, async active-low reset
// tx (slave) : line inputs, open-collector enables, SEND_BYTE/BYTE_TO_SEND request,
//              TX_BUSY, BYTE_SENT pulse, BYTE_ERROR_CODE {no_ack, timeout}
module mouse_transmitter
    import mouse_pkg::*;
#(
    parameter int CLK_HOLD_CYCLES = CLK_HOLD_CYCLES_50M,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_50M
) (
    input  logic               CLK,
    input  logic               RESET,
    mouse_transmitter_if.slave tx
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > CLK_HOLD_CYCLES) ? TIMEOUT_CYCLES : CLK_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CLK_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       shift_q, shift_d;     // {parity, byte}, shifted out LSB first
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             data_q, data_d;
    logic [1:0]       err_q, err_d;
    logic             fe;
    logic             wait_st;
    logic             byte_sent;

    ps2_edge_detect u_edge (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .line_i (tx.CLK_MOUSE_IN),
        .fe_o   (fe)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    // States in which the device owns the clock and the timeout applies
    assign wait_st = (state_q != S_IDLE) && (state_q != S_INHIBIT);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        byte_sent = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx.SEND_BYTE) begin
                    shift_d = {odd_parity(tx.BYTE_TO_SEND), tx.BYTE_TO_SEND};
                    err_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                data_d = 1'b0;                  // start bit, driven from REQ onwards
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fe) begin
                    data_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = S_SEND_DATA;
                end
            end
            S_SEND_DATA: begin
                if (fe) begin
                    // after eight shifts shift_q[0] holds the parity bit
                    data_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (fe) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (fe) begin
                    err_d[ERR_NO_ACK] = tx.DATA_MOUSE_IN;
                    state_d           = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (tx.CLK_MOUSE_IN && tx.DATA_MOUSE_IN) begin
                    byte_sent = ~err_q[ERR_NO_ACK];
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Progress takes priority over an expiring wait in the same cycle
        if (wait_st && !fe && (state_d == state_q) && (cnt_q == TIMEOUT_LAST)) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d            = S_IDLE;
        end

        if ((state_q == S_IDLE) || (state_d != state_q) || (wait_st && fe)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tx.CLK_MOUSE_OUT_EN  = (state_q == S_INHIBIT);
    assign tx.DATA_MOUSE_OUT_EN = (state_q == S_REQ) || (state_q == S_SEND_DATA) || (state_q == S_STOP);
    assign tx.DATA_MOUSE_OUT    = tx.DATA_MOUSE_OUT_EN & data_q;
    assign tx.TX_BUSY           = (state_q != S_IDLE);
    assign tx.BYTE_SENT         = byte_sent;
    assign tx.BYTE_ERROR_CODE   = err_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// tb/tb_mouse_transmitter.sv - self-checking bench for mouse_transmitter with a PS/2 device model
module tb_mouse_transmitter;
    import mouse_pkg::*;

    localparam int HOLD = 200;
    localparam int TOUT = 3000;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   sent_cnt = 0;
    int   inh_run  = 0;
    int   inh_last = 0;

    mouse_transmitter_if ifc ();

    // open-collector bus: either side can only pull a line low
    assign ifc.CLK_MOUSE_IN  = dev_clk & ~ifc.CLK_MOUSE_OUT_EN;
    assign ifc.DATA_MOUSE_IN = dev_data & ~(ifc.DATA_MOUSE_OUT_EN & ~ifc.DATA_MOUSE_OUT);

    mouse_transmitter #(
        .CLK_HOLD_CYCLES (HOLD),
        .TIMEOUT_CYCLES  (TOUT)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .tx    (ifc)
    );

    always #10 clk = ~clk;

    initial begin
        #1_200_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame as seen by the device: start, 8 data LSB first, odd parity, stop
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            if (b[i]) ones++;
        end
        f[0]  = 1'b0;
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // One system cycle: sample at negedge, return at posedge+1 ready to drive
    task automatic step();
        @(negedge clk);
        if (ifc.BYTE_SENT === 1'b1) sent_cnt++;
        if (ifc.CLK_MOUSE_OUT_EN === 1'b1) begin
            inh_run++;
        end else if (inh_run != 0) begin
            inh_last = inh_run;
            inh_run  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_send(input logic [7:0] b);
        ifc.SEND_BYTE    = 1'b1;
        ifc.BYTE_TO_SEND = b;
        step();
        ifc.SEND_BYTE    = 1'b0;
        ifc.BYTE_TO_SEND = 8'h00;
    endtask

    // Device side: wait for host request, clock out 11 edges, optionally stop after fe #abort_fe
    task automatic device_frame(input int half, input logic ack_bit, input int abort_fe,
                                output logic [10:0] got);
        int guard;
        got   = '0;
        guard = 0;
        while (ifc.CLK_MOUSE_OUT_EN !== 1'b1 && guard < 20) begin step(); guard++; end
        while (ifc.CLK_MOUSE_OUT_EN === 1'b1 && guard < HOLD + 40) begin step(); guard++; end
        chk("req_release", 32'(ifc.CLK_MOUSE_OUT_EN), 32'd0);
        got[0] = ifc.DATA_MOUSE_IN;
        for (int k = 1; k <= 11; k++) begin
            steps(half);
            dev_clk = 1'b0;
            if (k == abort_fe) return;
            steps(half);
            if (k <= 10) got[k] = ifc.DATA_MOUSE_IN;
            dev_clk = 1'b1;
            if (k == 10) dev_data = ack_bit;
            if (k == 11) dev_data = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input int half, input logic nack, input string tag);
        logic [10:0] got;
        int s0;
        s0 = sent_cnt;
        start_send(b);
        device_frame(half, nack, 0, got);
        steps(4);
        chk({tag, "_frame"}, 32'(got), 32'(ref_frame(b)));
        chk({tag, "_inhibit"}, 32'(inh_last), 32'(HOLD));
        chk({tag, "_sent"}, 32'(sent_cnt - s0), nack ? 32'd0 : 32'd1);
        chk({tag, "_err"}, 32'(ifc.BYTE_ERROR_CODE), nack ? 32'd2 : 32'd0);
        chk({tag, "_busy"}, 32'(ifc.TX_BUSY), 32'd0);
    endtask

    initial begin
        logic [10:0] got;
        logic [7:0]  b;
        int          n;
        int          s0;

        ifc.SEND_BYTE    = 1'b0;
        ifc.BYTE_TO_SEND = 8'h00;
        steps(3);
        chk("rst_busy",    32'(ifc.TX_BUSY), 32'd0);
        chk("rst_clk_en",  32'(ifc.CLK_MOUSE_OUT_EN), 32'd0);
        chk("rst_data_en", 32'(ifc.DATA_MOUSE_OUT_EN), 32'd0);
        chk("rst_data",    32'(ifc.DATA_MOUSE_OUT), 32'd0);
        chk("rst_sent",    32'(ifc.BYTE_SENT), 32'd0);
        chk("rst_err",     32'(ifc.BYTE_ERROR_CODE), 32'd0);
        rst_n = 1'b1;
        steps(2);

        run_frame(CMD_ENABLE_REPORTING, 20, 1'b0, "f4");
        chk("f4_bits", 32'(got_bits(CMD_ENABLE_REPORTING)), 32'h0F4);
        run_frame(CMD_RESET, 15, 1'b0, "ff");
        chk("ff_parity", 32'(ref_frame(CMD_RESET) >> 9), 32'd3);
        run_frame(8'h3C, 12, 1'b1, "nack");

        // request while busy must not disturb the frame in flight
        s0 = sent_cnt;
        start_send(CMD_ENABLE_REPORTING);
        steps(5);
        ifc.SEND_BYTE    = 1'b1;
        ifc.BYTE_TO_SEND = 8'h55;
        step();
        ifc.SEND_BYTE    = 1'b0;
        ifc.BYTE_TO_SEND = 8'h00;
        device_frame(18, 1'b0, 0, got);
        steps(4);
        chk("busy_frame",   32'(got), 32'(ref_frame(CMD_ENABLE_REPORTING)));
        chk("busy_inhibit", 32'(inh_last), 32'(HOLD));
        chk("busy_sent",    32'(sent_cnt - s0), 32'd1);
        chk("busy_idle",    32'(ifc.TX_BUSY), 32'd0);

        // device never clocks: abort after TOUT cycles in REQ
        s0 = sent_cnt;
        start_send(8'hA5);
        n = 0;
        while (ifc.CLK_MOUSE_OUT_EN === 1'b1 && n < HOLD + 40) begin step(); n++; end
        n = 0;
        while (ifc.TX_BUSY === 1'b1 && n < TOUT + 50) begin step(); n++; end
        chk("to_latency", 32'(n), 32'(TOUT));
        chk("to_err",     32'(ifc.BYTE_ERROR_CODE), 32'd1);
        chk("to_clk_en",  32'(ifc.CLK_MOUSE_OUT_EN), 32'd0);
        chk("to_data_en", 32'(ifc.DATA_MOUSE_OUT_EN), 32'd0);
        steps(2);
        chk("to_sent",    32'(sent_cnt - s0), 32'd0);

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(255, 0));
            run_frame(b, $urandom_range(40, 8), ($urandom_range(2, 0) == 0), $sformatf("rnd%0d", i));
        end

        // reset in the low phase of fe #5
        start_send(CMD_ENABLE_REPORTING);
        device_frame(20, 1'b0, 5, got);
        steps(3);
        chk("mid_data_en_before", 32'(ifc.DATA_MOUSE_OUT_EN), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy",    32'(ifc.TX_BUSY), 32'd0);
        chk("mid_clk_en",  32'(ifc.CLK_MOUSE_OUT_EN), 32'd0);
        chk("mid_data_en", 32'(ifc.DATA_MOUSE_OUT_EN), 32'd0);
        chk("mid_data",    32'(ifc.DATA_MOUSE_OUT), 32'd0);
        chk("mid_sent",    32'(ifc.BYTE_SENT), 32'd0);
        dev_clk = 1'b1;
        steps(2);
        rst_n = 1'b1;
        steps(2);
        run_frame(CMD_ENABLE_REPORTING, 25, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Data bits of the reference frame packed back into a byte, for the literal 0xF4 check
    function automatic logic [8:0] got_bits(input logic [7:0] b);
        logic [10:0] f;
        f = ref_frame(b);
        return {1'b0, f[8:1]};
    endfunction

endmodule
